// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: decode/writeback side (master) and register file (slave).
interface regfile_mp_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5,
  parameter int NRP  = 2
);
  logic                clear_req;
  logic                we;
  logic [AW-1:0]       waddr;
  logic [XLEN-1:0]     wdata;
  logic [NRP*AW-1:0]   raddr;
  logic [NRP*XLEN-1:0] rdata;
  logic                busy;
  logic                wr_drop;

  modport master (
    output clear_req, we, waddr, wdata, raddr,
    input  rdata, busy, wr_drop
  );

  modport slave (
    input  clear_req, we, waddr, wdata, raddr,
    output rdata, busy, wr_drop
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-read-port register file with hardwired-zero x0 and a sequential clear engine.
// Optional same-cycle write-to-read forwarding is enabled by defining RF_BYPASS_EN.
module regfile_mp #(
  parameter int XLEN = 32,
  parameter int AW   = 5,
  parameter int NRP  = 2
) (
  input  logic         clk,
  input  logic         reset,
  regfile_mp_if.slave  bus
);
  localparam int NREGS = 2 ** AW;
  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);
  localparam logic [AW-1:0] FIRST_IDX = AW'(1);

  typedef enum logic {
    CLEAR,
    RUN
  } state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic              drop_q, drop_d;
  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic [XLEN-1:0]   mem_data;
  logic              wr_valid;
  logic              busy_w;
  logic [NRP*XLEN-1:0] rdata_c;

  // Entry 0 has no storage; reads of it are forced to zero below.
  logic [XLEN-1:0]   mem [1:NREGS-1];

  assign wr_valid = bus.we && (bus.waddr != '0);
  assign busy_w   = (state_q == CLEAR);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLEAR;
      idx_q   <= FIRST_IDX;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    mem_we   = 1'b0;
    mem_addr = bus.waddr;
    mem_data = bus.wdata;
    drop_d   = 1'b0;

    case (state_q)
      CLEAR: begin
        mem_we   = 1'b1;
        mem_addr = idx_q;
        mem_data = '0;
        idx_d    = idx_q + FIRST_IDX;
        if (idx_q == LAST_IDX) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (wr_valid && !bus.clear_req) begin
          mem_we = 1'b1;
        end
      end
      default: begin
        state_d = CLEAR;
        idx_d   = FIRST_IDX;
      end
    endcase

    // A clear request restarts the sweep from entry 1, even mid-clear.
    if (bus.clear_req) begin
      state_d = CLEAR;
      idx_d   = FIRST_IDX;
    end

    drop_d = wr_valid && (busy_w || bus.clear_req);
  end

  always_ff @(posedge clk) begin
    if (!reset && mem_we) begin
      mem[mem_addr] <= mem_data;
    end
  end

  always_comb begin
    logic [AW-1:0] addr;
    rdata_c = '0;
    addr    = '0;
    for (int p = 0; p < NRP; p++) begin
      addr = bus.raddr[p*AW +: AW];
      if (!busy_w && (addr != '0)) begin
        rdata_c[p*XLEN +: XLEN] = mem[addr];
      end
`ifdef RF_BYPASS_EN
      if (!busy_w && !bus.clear_req && wr_valid && (bus.waddr == addr)) begin
        rdata_c[p*XLEN +: XLEN] = bus.wdata;
      end
`endif
    end
  end

  assign bus.rdata   = rdata_c;
  assign bus.busy    = busy_w;
  assign bus.wr_drop = drop_q;
endmodule
